// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes stage: substitutes BPC state bytes per clock behind valid/ready handshakes.
// Optional macro SUB_BYTES_FWD_EN adds a 'mode' port that selects the forward S-box (mode=1) per block.
module inv_sub_bytes_iter #(
  parameter int BPC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef SUB_BYTES_FWD_EN
  input  logic         mode,
`endif
  output logic [127:0] out_data
);

  localparam int NGROUPS = 16 / BPC;
  localparam int IDX_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

  generate
    if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bad_bpc
      $error("inv_sub_bytes_iter: BPC must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_work [16];
  logic             w_last;
  logic [7:0]       w_lane_in  [BPC];
  logic [7:0]       w_lane_out [BPC];
  logic [3:0]       w_pos      [BPC];

  // GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1; inverse computed as x^254 (maps 0 to 0).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] r;
    t = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

`ifdef SUB_BYTES_FWD_EN
  logic r_mode;

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction
`endif

  generate
    for (genvar g = 0; g < BPC; g++) begin : g_lane
      assign w_pos[g]     = 4'(int'(r_idx) * BPC + g);
      assign w_lane_in[g] = r_work[w_pos[g]];
`ifdef SUB_BYTES_FWD_EN
      assign w_lane_out[g] = r_mode ? fwd_sbox(w_lane_in[g]) : inv_sbox(w_lane_in[g]);
`else
      assign w_lane_out[g] = inv_sbox(w_lane_in[g]);
`endif
    end
  endgenerate

  assign w_last = (r_idx == IDX_W'(NGROUPS - 1));

  // NOTE: every output of this block is given a default first, so no path leaves a latch.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = S_BUSY;
      end
      S_BUSY: begin
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      // NOTE: the byte bank is reset on purpose because out_data must read zero after reset.
      for (int k = 0; k < 16; k++) r_work[k] <= 8'h00;
`ifdef SUB_BYTES_FWD_EN
      r_mode  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && in_valid) begin
        for (int k = 0; k < 16; k++) r_work[k] <= in_data[127-8*k -: 8];
        r_idx <= '0;
`ifdef SUB_BYTES_FWD_EN
        r_mode <= mode;
`endif
      end else if (r_state == S_BUSY) begin
        for (int g = 0; g < BPC; g++) r_work[w_pos[g]] <= w_lane_out[g];
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < 16; k++) out_data[127-8*k -: 8] = r_work[k];
  end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Self-checking bench for inv_sub_bytes_iter: directed vectors plus random blocks against a table-based S-box model.
module tb_inv_sub_bytes_iter;

  localparam int BPC     = 4;
  localparam int NGROUPS = 16 / BPC;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef SUB_BYTES_FWD_EN
  logic         mode;
`endif

  int n_checks;
  int n_fail;

  logic [7:0] fwd_tbl [256];
  logic [7:0] inv_tbl [256];

  inv_sub_bytes_iter #(.BPC(BPC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SUB_BYTES_FWD_EN
    .mode      (mode),
`endif
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Carry-less product then reduction modulo 0x11b.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      y = 8'h00;
      if (v != 0)
        for (int w = 1; w < 256; w++)
          if (ref_mul(x, 8'(w)) == 8'h01) y = 8'(w);
      for (int i = 0; i < 8; i++)
        s[i] = y[i] ^ y[(i+4)%8] ^ y[(i+5)%8] ^ y[(i+6)%8] ^ y[(i+7)%8] ^ c[i];
      fwd_tbl[v] = s;
      inv_tbl[s] = x;
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] d, input logic m);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      b = d[127-8*k -: 8];
      r[127-8*k -: 8] = m ? fwd_tbl[b] : inv_tbl[b];
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_mode(input logic m);
`ifdef SUB_BYTES_FWD_EN
    mode = m;
`else
    if (m) $display("note: mode ignored in this build");
`endif
  endtask

  task automatic wait_ready();
    int cnt;
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("in_ready_wait", 128'(in_ready), 128'd1);
  endtask

  // One block: accept, measure latency, compare result, optional stall, handshake.
  task automatic do_block(input string tag, input logic [127:0] d, input logic m,
                          input logic [127:0] exp, input int stall, input bit noisy);
    int cnt;
    wait_ready();
    in_valid = 1'b1;
    in_data  = d;
    set_mode(m);
    @(posedge clk); #1;
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      if (noisy) begin
        in_valid = 1'b1;
        in_data  = rnd128();
        set_mode(1'($urandom));
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      cnt++;
    end
    in_valid = 1'b0;
    in_data  = rnd128();
    check({tag, "_latency"}, 128'(cnt), 128'(NGROUPS));
    check({tag, "_data"}, out_data, exp);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check({tag, "_stall_valid"}, 128'(out_valid), 128'd1);
      check({tag, "_stall_ready"}, 128'(in_ready), 128'd0);
      check({tag, "_stall_data"}, out_data, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_post_valid"}, 128'(out_valid), 128'd0);
    check({tag, "_post_ready"}, 128'(in_ready), 128'd1);
    check({tag, "_post_hold"}, out_data, exp);
  endtask

  logic [127:0] d;
  logic         m;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    set_mode(1'b0);
    build_tables();

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    rst_n = 1'b1;

    d = 128'h000102030405060708090a0b0c0d0e0f;
    do_block("vec_seq", d, 1'b0, 128'h52096ad53036a538bf40a39e81f3d7fb, 0, 1'b0);
    check("vec_seq_model", model(d, 1'b0), 128'h52096ad53036a538bf40a39e81f3d7fb);
    do_block("vec_63", {16{8'h63}}, 1'b0, {16{8'h00}}, 0, 1'b0);
    do_block("vec_ff", {16{8'hff}}, 1'b0, {16{8'h7d}}, 0, 1'b0);
    d = rnd128();
    do_block("stall10", d, 1'b0, model(d, 1'b0), 10, 1'b0);
    d = rnd128();
    do_block("noisy", d, 1'b0, model(d, 1'b0), 2, 1'b1);

`ifdef SUB_BYTES_FWD_EN
    do_block("fwd_00", {16{8'h00}}, 1'b1, {16{8'h63}}, 0, 1'b0);
    do_block("fwd_53", {16{8'h53}}, 1'b1, {16{8'hed}}, 0, 1'b0);
    d = rnd128();
    do_block("fwd_rnd", d, 1'b1, model(d, 1'b1), 1, 1'b1);
`endif

    // Reset in the middle of BUSY discards the block.
    wait_ready();
    in_valid = 1'b1;
    in_data  = rnd128();
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    check("midrst_out_data", out_data, 128'd0);
    rst_n = 1'b1;
    for (int i = 0; i < NGROUPS + 4; i++) begin
      @(posedge clk); #1;
      check("midrst_no_stray", 128'(out_valid), 128'd0);
    end

    for (int i = 0; i < 24; i++) begin
      d = rnd128();
`ifdef SUB_BYTES_FWD_EN
      m = 1'($urandom);
`else
      m = 1'b0;
`endif
      do_block("rnd", d, m, model(d, m), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
